// File: rtl/countdown_timer_core.sv
// Countdown/count-up timer core: five-state control FSM, preset editor,
// binary working count with combinational BCD display, and an LED bar
// that indicates the run/done status.
module countdown_timer_core #(
  parameter int HI_MAX      = 23,
  parameter int LO_MAX      = 59,
  parameter int LED_W       = 16,
  parameter int COUNT_UP    = 0,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             set_mode,
  input  logic             inc_hi,
  input  logic             inc_lo,
  input  logic             start_stop,
  input  logic             pause_resume,
  output logic [3:0]       hi_t,
  output logic [3:0]       hi_s,
  output logic [3:0]       lo_t,
  output logic [3:0]       lo_s,
  output logic             running,
  output logic             paused,
  output logic             done,
  output logic [LED_W-1:0] led
);

  localparam logic [6:0]       HI_MAX_V = 7'(HI_MAX);
  localparam logic [6:0]       LO_MAX_V = 7'(LO_MAX);
  localparam logic [LED_W-1:0] LED_ONE  = {{(LED_W-1){1'b0}}, 1'b1};
  localparam bit               AUTO_RL  = (AUTO_RELOAD != 0);

  typedef enum logic [2:0] {IDLE, SET, RUN, PAUSE, DONE} state_t;

  state_t           r_state, w_state_next;
  logic [6:0]       r_pre_hi, r_pre_lo, w_pre_hi_next, w_pre_lo_next;
  logic [6:0]       r_cnt_hi, r_cnt_lo, w_cnt_hi_next, w_cnt_lo_next;
  logic             r_done, w_done_next;
  logic [LED_W-1:0] r_led, w_led_next, w_led_rot;

  logic [6:0]       w_start_hi, w_start_lo, w_tgt_hi, w_tgt_lo;
  logic [6:0]       w_step_hi, w_step_lo;
  logic             w_pre_zero, w_at_tgt;
  logic [6:0]       w_disp_hi, w_disp_lo;
  logic [7:0]       w_bcd_hi, w_bcd_lo;

  // Binary 0..99 to two BCD digits. The units digit is taken modulo 16,
  // which is exact because the true remainder is always below 10.
  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (v >= 7'(k * 10)) tens = 4'(k);
    end
    units = v[3:0] - (tens * 4'd10);
    return {tens, units};
  endfunction

  // Direction-dependent start value, target value and single-tick step.
  generate
    if (COUNT_UP != 0) begin : g_up
      assign w_start_hi = 7'd0;
      assign w_start_lo = 7'd0;
      assign w_tgt_hi   = r_pre_hi;
      assign w_tgt_lo   = r_pre_lo;
      // Up step: minute field rolls into the hour field at LO_MAX.
      always_comb begin
        w_step_hi = r_cnt_hi;
        w_step_lo = r_cnt_lo + 7'd1;
        if (r_cnt_lo == LO_MAX_V) begin
          w_step_hi = r_cnt_hi + 7'd1;
          w_step_lo = 7'd0;
        end
      end
    end else begin : g_down
      assign w_start_hi = r_pre_hi;
      assign w_start_lo = r_pre_lo;
      assign w_tgt_hi   = 7'd0;
      assign w_tgt_lo   = 7'd0;
      // Down step: minute field borrows from the hour field at zero.
      always_comb begin
        w_step_hi = r_cnt_hi;
        w_step_lo = r_cnt_lo - 7'd1;
        if (r_cnt_lo == 7'd0) begin
          w_step_hi = r_cnt_hi - 7'd1;
          w_step_lo = LO_MAX_V;
        end
      end
    end
  endgenerate

  assign w_pre_zero = (r_pre_hi == 7'd0) && (r_pre_lo == 7'd0);
  assign w_at_tgt   = (w_step_hi == w_tgt_hi) && (w_step_lo == w_tgt_lo);
  assign w_led_rot  = {r_led[LED_W-2:0], r_led[LED_W-1]};

  // Next-state, preset, count, done and LED logic; set_mode overrides all.
  always_comb begin
    w_state_next  = r_state;
    w_pre_hi_next = r_pre_hi;
    w_pre_lo_next = r_pre_lo;
    w_cnt_hi_next = r_cnt_hi;
    w_cnt_lo_next = r_cnt_lo;
    w_done_next   = 1'b0;
    w_led_next    = r_led;
    if (set_mode) begin
      w_state_next = SET;
      w_led_next   = '0;
      if (r_state == SET) begin
        if (inc_hi) w_pre_hi_next = (r_pre_hi == HI_MAX_V) ? 7'd0 : r_pre_hi + 7'd1;
        if (inc_lo) w_pre_lo_next = (r_pre_lo == LO_MAX_V) ? 7'd0 : r_pre_lo + 7'd1;
      end
    end else begin
      case (r_state)
        SET: begin
          w_state_next  = IDLE;
          w_cnt_hi_next = w_start_hi;
          w_cnt_lo_next = w_start_lo;
          w_led_next    = '0;
        end
        IDLE: begin
          if (start_stop && !w_pre_zero) begin
            w_state_next  = RUN;
            w_cnt_hi_next = w_start_hi;
            w_cnt_lo_next = w_start_lo;
            w_led_next    = LED_ONE;
          end
        end
        RUN: begin
          if (start_stop) begin
            w_state_next  = IDLE;
            w_cnt_hi_next = w_start_hi;
            w_cnt_lo_next = w_start_lo;
            w_led_next    = '0;
          end else if (pause_resume) begin
            w_state_next = PAUSE;
          end else if (tick) begin
            w_led_next = w_led_rot;
            if (w_at_tgt) begin
              w_done_next = 1'b1;
              if (AUTO_RL) begin
                w_cnt_hi_next = w_start_hi;
                w_cnt_lo_next = w_start_lo;
              end else begin
                w_state_next  = DONE;
                w_cnt_hi_next = w_step_hi;
                w_cnt_lo_next = w_step_lo;
                w_led_next    = '1;
              end
            end else begin
              w_cnt_hi_next = w_step_hi;
              w_cnt_lo_next = w_step_lo;
            end
          end
        end
        PAUSE: begin
          if (start_stop) begin
            w_state_next  = IDLE;
            w_cnt_hi_next = w_start_hi;
            w_cnt_lo_next = w_start_lo;
            w_led_next    = '0;
          end else if (pause_resume) begin
            w_state_next = RUN;
          end
        end
        DONE: begin
          if (start_stop) begin
            w_state_next  = IDLE;
            w_cnt_hi_next = w_start_hi;
            w_cnt_lo_next = w_start_lo;
            w_led_next    = '0;
          end else if (tick) begin
            w_led_next = ~r_led;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_led_next   = '0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Preset, working count, done pulse and LED registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_hi <= 7'd0;
      r_pre_lo <= 7'd0;
      r_cnt_hi <= 7'd0;
      r_cnt_lo <= 7'd0;
      r_done   <= 1'b0;
      r_led    <= '0;
    end else begin
      r_pre_hi <= w_pre_hi_next;
      r_pre_lo <= w_pre_lo_next;
      r_cnt_hi <= w_cnt_hi_next;
      r_cnt_lo <= w_cnt_lo_next;
      r_done   <= w_done_next;
      r_led    <= w_led_next;
    end
  end

  // SET shows the preset being edited; every other state shows the count.
  assign w_disp_hi = (r_state == SET) ? r_pre_hi : r_cnt_hi;
  assign w_disp_lo = (r_state == SET) ? r_pre_lo : r_cnt_lo;
  assign w_bcd_hi  = bin2bcd(w_disp_hi);
  assign w_bcd_lo  = bin2bcd(w_disp_lo);

  assign hi_t    = w_bcd_hi[7:4];
  assign hi_s    = w_bcd_hi[3:0];
  assign lo_t    = w_bcd_lo[7:4];
  assign lo_s    = w_bcd_lo[3:0];
  assign running = (r_state == RUN);
  assign paused  = (r_state == PAUSE);
  assign done    = r_done;
  assign led     = r_led;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Bench for countdown_timer_core: one default (down-count) instance and one
// up-count auto-reload instance, checked through an expected/observed queue.
module tb_countdown_timer_core;

  logic clk, rst_n;
  logic tick, set_mode, inc_hi, inc_lo, start_stop, pause_resume;
  logic [3:0] hi_t, hi_s, lo_t, lo_s;
  logic running, paused, done;
  logic [15:0] led;

  logic u_tick, u_set_mode, u_inc_hi, u_inc_lo, u_start_stop, u_pause_resume;
  logic [3:0] u_hi_t, u_hi_s, u_lo_t, u_lo_s;
  logic u_running, u_paused, u_done;
  logic [15:0] u_led;

  typedef struct packed {
    logic [15:0] disp;
    logic        run;
    logic        pau;
    logic        dn;
    logic [15:0] led;
  } obs_t;

  obs_t obs_d, obs_u;
  obs_t exp_q[$];
  obs_t got_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  countdown_timer_core dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .set_mode(set_mode),
    .inc_hi(inc_hi), .inc_lo(inc_lo), .start_stop(start_stop),
    .pause_resume(pause_resume), .hi_t(hi_t), .hi_s(hi_s), .lo_t(lo_t),
    .lo_s(lo_s), .running(running), .paused(paused), .done(done), .led(led)
  );

  countdown_timer_core #(.COUNT_UP(1), .AUTO_RELOAD(1)) dut_up (
    .clk(clk), .rst_n(rst_n), .tick(u_tick), .set_mode(u_set_mode),
    .inc_hi(u_inc_hi), .inc_lo(u_inc_lo), .start_stop(u_start_stop),
    .pause_resume(u_pause_resume), .hi_t(u_hi_t), .hi_s(u_hi_s), .lo_t(u_lo_t),
    .lo_s(u_lo_s), .running(u_running), .paused(u_paused), .done(u_done),
    .led(u_led)
  );

  assign obs_d = {hi_t, hi_s, lo_t, lo_s, running, paused, done, led};
  assign obs_u = {u_hi_t, u_hi_s, u_lo_t, u_lo_s, u_running, u_paused, u_done, u_led};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected observation: display hh:ll, flags and LED bar.
  function automatic obs_t mk(int h, int l, bit run, bit pau, bit dn, logic [15:0] ld);
    obs_t e;
    e.disp = {4'(h / 10), 4'(h % 10), 4'(l / 10), 4'(l % 10)};
    e.run  = run;
    e.pau  = pau;
    e.dn   = dn;
    e.led  = ld;
    return e;
  endfunction

  // One clock of stimulus on the default instance; expected value queued.
  task automatic drv_d(input bit sm, t, ih, il, ss, pr, input obs_t e);
    set_mode = sm; tick = t; inc_hi = ih; inc_lo = il;
    start_stop = ss; pause_resume = pr;
    exp_q.push_back(e);
    @(negedge clk);
    tick = 0; inc_hi = 0; inc_lo = 0; start_stop = 0; pause_resume = 0;
    got_q.push_back(obs_d);
  endtask

  // One clock of stimulus on the up-count instance; expected value queued.
  task automatic drv_u(input bit sm, t, ih, il, ss, pr, input obs_t e);
    u_set_mode = sm; u_tick = t; u_inc_hi = ih; u_inc_lo = il;
    u_start_stop = ss; u_pause_resume = pr;
    exp_q.push_back(e);
    @(negedge clk);
    u_tick = 0; u_inc_hi = 0; u_inc_lo = 0; u_start_stop = 0; u_pause_resume = 0;
    got_q.push_back(obs_u);
  endtask

  task automatic test_reset();
    obs_t e, g;
    int idx = 0;
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 16'h0000)); got_q.push_back(obs_d);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 16'h0000)); got_q.push_back(obs_u);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 16'h0000)); got_q.push_back(obs_d);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 16'h0000)); got_q.push_back(obs_u);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL reset[%0d]: got %h want %h", idx, g, e);
      end else $display("reset[%0d] ok %h", idx, g);
      idx++;
    end
  endtask

  task automatic test_down();
    obs_t e, g;
    int idx = 0;
    drv_d(1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 16'h0000));
    drv_d(1, 0, 0, 1, 0, 0, mk(0, 1, 0, 0, 0, 16'h0000));
    drv_d(1, 0, 0, 1, 0, 0, mk(0, 2, 0, 0, 0, 16'h0000));
    drv_d(0, 0, 0, 0, 0, 0, mk(0, 2, 0, 0, 0, 16'h0000));
    drv_d(0, 0, 1, 1, 0, 1, mk(0, 2, 0, 0, 0, 16'h0000));
    drv_d(0, 0, 0, 0, 1, 0, mk(0, 2, 1, 0, 0, 16'h0001));
    drv_d(0, 1, 0, 0, 0, 0, mk(0, 1, 1, 0, 0, 16'h0002));
    drv_d(0, 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 16'hffff));
    drv_d(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 16'hffff));
    drv_d(0, 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 16'h0000));
    drv_d(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 16'h0000));
    drv_d(0, 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 16'hffff));
    drv_d(0, 0, 0, 0, 1, 0, mk(0, 2, 0, 0, 0, 16'h0000));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL down[%0d]: got %h want %h", idx, g, e);
      end else $display("down[%0d] ok %h", idx, g);
      idx++;
    end
  endtask

  task automatic test_pause();
    obs_t e, g;
    int idx = 0;
    drv_d(1, 0, 0, 0, 0, 0, mk(0, 2, 0, 0, 0, 16'h0000));
    drv_d(1, 0, 1, 0, 0, 0, mk(1, 2, 0, 0, 0, 16'h0000));
    for (int i = 1; i <= 58; i++)
      drv_d(1, 0, 0, 1, 0, 0, mk(1, (2 + i) % 60, 0, 0, 0, 16'h0000));
    drv_d(0, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 16'h0000));
    drv_d(0, 0, 0, 0, 1, 0, mk(1, 0, 1, 0, 0, 16'h0001));
    drv_d(0, 1, 0, 0, 0, 0, mk(0, 59, 1, 0, 0, 16'h0002));
    drv_d(0, 0, 0, 0, 0, 1, mk(0, 59, 0, 1, 0, 16'h0002));
    for (int i = 0; i < 5; i++)
      drv_d(0, 1, 0, 0, 0, 0, mk(0, 59, 0, 1, 0, 16'h0002));
    drv_d(0, 0, 0, 0, 0, 1, mk(0, 59, 1, 0, 0, 16'h0002));
    drv_d(0, 1, 0, 0, 0, 0, mk(0, 58, 1, 0, 0, 16'h0004));
    drv_d(0, 0, 0, 0, 1, 1, mk(1, 0, 0, 0, 0, 16'h0000));
    drv_d(0, 0, 0, 0, 1, 0, mk(1, 0, 1, 0, 0, 16'h0001));
    drv_d(0, 0, 0, 0, 0, 1, mk(1, 0, 0, 1, 0, 16'h0001));
    drv_d(0, 0, 0, 0, 1, 0, mk(1, 0, 0, 0, 0, 16'h0000));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL pause[%0d]: got %h want %h", idx, g, e);
      end else $display("pause[%0d] ok %h", idx, g);
      idx++;
    end
  endtask

  task automatic test_wrap();
    obs_t e, g;
    int idx = 0;
    drv_d(1, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0, 16'h0000));
    for (int i = 1; i <= 24; i++)
      drv_d(1, 0, 1, 0, 0, 0, mk((1 + i) % 24, 0, 0, 0, 0, 16'h0000));
    for (int i = 1; i <= 60; i++)
      drv_d(1, 0, 0, 1, 0, 0, mk(1, i % 60, 0, 0, 0, 16'h0000));
    drv_d(1, 0, 1, 1, 0, 0, mk(2, 1, 0, 0, 0, 16'h0000));
    for (int i = 1; i <= 22; i++)
      drv_d(1, 0, 1, 0, 0, 0, mk((2 + i) % 24, 1, 0, 0, 0, 16'h0000));
    for (int i = 1; i <= 59; i++)
      drv_d(1, 0, 0, 1, 0, 0, mk(0, (1 + i) % 60, 0, 0, 0, 16'h0000));
    drv_d(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 16'h0000));
    drv_d(0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 16'h0000));
    drv_d(0, 1, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 16'h0000));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got %h want %h", idx, g, e);
      end else $display("wrap[%0d] ok %h", idx, g);
      idx++;
    end
  endtask

  task automatic test_up_reload();
    obs_t e, g;
    int idx = 0;
    drv_u(1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 16'h0000));
    for (int i = 1; i <= 3; i++)
      drv_u(1, 0, 0, 1, 0, 0, mk(0, i, 0, 0, 0, 16'h0000));
    drv_u(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 16'h0000));
    drv_u(0, 0, 0, 0, 1, 0, mk(0, 0, 1, 0, 0, 16'h0001));
    for (int k = 1; k <= 18; k++)
      drv_u(0, 1, 0, 0, 0, 0, mk(0, k % 3, 1, 0, (k % 3 == 0), 16'(1 << (k % 16))));
    drv_u(0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 16'h0000));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL up_reload[%0d]: got %h want %h", idx, g, e);
      end else $display("up_reload[%0d] ok %h", idx, g);
      idx++;
    end
  endtask

  task automatic test_reset_midrun();
    obs_t e, g;
    int idx = 0;
    drv_d(1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 16'h0000));
    for (int i = 1; i <= 3; i++)
      drv_d(1, 0, 0, 1, 0, 0, mk(0, i, 0, 0, 0, 16'h0000));
    drv_d(0, 0, 0, 0, 0, 0, mk(0, 3, 0, 0, 0, 16'h0000));
    drv_d(0, 0, 0, 0, 1, 0, mk(0, 3, 1, 0, 0, 16'h0001));
    drv_d(0, 1, 0, 0, 0, 0, mk(0, 2, 1, 0, 0, 16'h0002));
    #2 rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 16'h0000)); got_q.push_back(obs_d);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 16'h0000)); got_q.push_back(obs_d);
    rst_n = 1'b1;
    drv_d(0, 1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 16'h0000));
    drv_d(0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 16'h0000));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL reset_midrun[%0d]: got %h want %h", idx, g, e);
      end else $display("reset_midrun[%0d] ok %h", idx, g);
      idx++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tick = 0; set_mode = 0; inc_hi = 0; inc_lo = 0; start_stop = 0; pause_resume = 0;
    u_tick = 0; u_set_mode = 0; u_inc_hi = 0; u_inc_lo = 0;
    u_start_stop = 0; u_pause_resume = 0;
    test_reset();
    test_down();
    test_pause();
    test_wrap();
    test_up_reload();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer_core.md
COUNTDOWN_TIMER_CORE -- requirements
Module: countdown_timer_core

Interface
REQ-001 Parameter HI_MAX, default 23, maximum value of the upper (hour) field, legal 1..99.
REQ-002 Parameter LO_MAX, default 59, maximum value of the lower (minute) field, legal 1..99.
REQ-003 Parameter LED_W, default 16, LED bar width, legal 2..32.
REQ-004 Parameter COUNT_UP, default 0: 0 counts down from the preset to 00:00; 1 counts up from 00:00 to the preset.
REQ-005 Parameter AUTO_RELOAD, default 0: 1 restarts the run after expiry instead of holding in DONE.
REQ-006 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 tick  input  1  one-cycle count enable from the frequency divider.
REQ-009 set_mode  input  1  level; 1 selects preset editing.
REQ-010 inc_hi, inc_lo  input  1 each  one-cycle pulses (already debounced) that increment the preset fields.
REQ-011 start_stop, pause_resume  input  1 each  one-cycle pulses (already debounced).
REQ-012 hi_t, hi_s, lo_t, lo_s  output  4 each  BCD tens and units of the displayed value.
REQ-013 running, paused  output  1 each  state flags.
REQ-014 done  output  1  one-cycle pulse on expiry.
REQ-015 led  output  LED_W  LED bar.

Function
REQ-016 The FSM SHALL have five states: IDLE, SET, RUN, PAUSE and DONE.
REQ-017 In any state, set_mode=1 SHALL move to SET; set_mode=0 in SET SHALL move to IDLE and load the count start value (preset for down-count, 00:00 for up-count).
REQ-018 In SET, inc_hi SHALL increment preset_hi, wrapping HI_MAX->0, and inc_lo SHALL increment preset_lo, wrapping LO_MAX->0; the two increments SHALL apply independently in the same cycle.
REQ-019 In SET, the display SHALL show the preset; in all other states, it SHALL show the working count.
REQ-020 In IDLE, start_stop SHALL enter RUN, except when the preset is 00:00, in which case the pulse SHALL be ignored.
REQ-021 In RUN or PAUSE, start_stop SHALL return to IDLE and reload the start value.
REQ-022 pause_resume SHALL toggle RUN<->PAUSE and SHALL be ignored in every other state.
REQ-023 start_stop SHALL take priority over pause_resume when both arrive in the same cycle.
REQ-024 The count SHALL change only in RUN on a tick cycle and SHALL hold in PAUSE.
REQ-025 Down-count step: if lo>0 then lo-1; else hi-1 and lo=LO_MAX.
REQ-026 Up-count step: if lo<LO_MAX then lo+1; else lo=0 and hi+1.
REQ-027 Expiry SHALL occur on the tick step that makes the count equal the target (00:00 for down-count, the preset for up-count).
REQ-028 On expiry, done SHALL pulse high in the cycle after that step and the FSM SHALL enter DONE; if AUTO_RELOAD=1, it SHALL instead reload and stay in RUN, with done still pulsing.
REQ-029 In DONE, start_stop SHALL go to IDLE with reload; all other pulses SHALL be ignored.
REQ-030 running SHALL be 1 only in RUN; paused SHALL be 1 only in PAUSE.
REQ-031 LED pattern per state:
- IDLE/SET: all zeros.
- RUN: one-hot, starting at bit 0 on RUN entry and rotating one position toward the MSB per tick, wrapping MSB->bit 0.
- PAUSE: frozen.
- DONE: all bits toggle together each tick, starting from all ones.
REQ-032 The count and the preset SHALL be stored in binary; BCD outputs SHALL be produced combinationally with no added latency.

Reset
REQ-033 While rst_n=0, the block SHALL hold: state IDLE, preset 00:00, count 00:00, all BCD outputs 0, running=0, paused=0, done=0, led=0.
REQ-034 Reset asserted in mid-run SHALL abandon the run immediately, with no done pulse.

Verification
REQ-035 Default parameters: set the preset to 00:02 via two inc_lo pulses, start, apply 2 ticks -> display 00:01 then 00:00, done pulses once, FSM in DONE, led=all ones.
REQ-036 Pause: run from 01:00, then tick (display 00:59), pause, apply 5 ticks -> display still 00:59 and led frozen; resume plus 1 tick -> display 00:58.
REQ-037 Wrap: 24 inc_hi pulses -> preset_hi=0; 60 inc_lo pulses -> preset_lo=0; start_stop with a 00:00 preset -> FSM stays in IDLE.
REQ-038 COUNT_UP=1, AUTO_RELOAD=1, preset 00:03: apply 7 ticks -> done pulses after tick 3 and tick 6; display 00:01 after tick 7.
REQ-039 start_stop and pause_resume in the same cycle while in RUN -> FSM goes to IDLE with the count reloaded; rst_n low in RUN -> all outputs 0 asynchronously.
